// File: rtl/multi_message_buffer_if.sv
// Bus bundle for multi_message_buffer: word-by-word producer side plus
// the whole-message head view presented to the consumer.
interface multi_message_buffer_if #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int SEL_W          = 4,
    parameter int TGA_W          = 2,
    parameter int TGC_W          = 2,
    parameter int MAX_BURST      = 8,
    parameter int N_BITS_VNET_ID = 2
);
    localparam int LEN_W = $clog2(MAX_BURST) + 1;

    logic [ADDR_W-1:0]           ADR_I;
    logic [DATA_W-1:0]           DAT_I;
    logic [SEL_W-1:0]            SEL_I;
    logic [TGA_W-1:0]            TGA_I;
    logic [TGC_W-1:0]            TGC_I;
    logic                        WE_I;
    logic                        reply_i;
    logic                        is_valid_i;
    logic                        last_i;
    logic                        abort_i;
    logic                        stall_o;
    logic                        overflow_o;
    logic                        is_valid_o;
    logic                        ready_i;
    logic [ADDR_W-1:0]           adr_o;
    logic [TGA_W-1:0]            tga_o;
    logic [TGC_W-1:0]            tgc_o;
    logic                        we_o;
    logic                        reply_o;
    logic [MAX_BURST*DATA_W-1:0] data_o;
    logic [MAX_BURST*SEL_W-1:0]  sel_o;
    logic [LEN_W-1:0]            len_o;
    logic [N_BITS_VNET_ID-1:0]   vnet_id_o;

    modport slave (
        input  ADR_I, DAT_I, SEL_I, TGA_I, TGC_I, WE_I, reply_i,
        input  is_valid_i, last_i, abort_i, ready_i,
        output stall_o, overflow_o, is_valid_o, adr_o, tga_o, tgc_o,
        output we_o, reply_o, data_o, sel_o, len_o, vnet_id_o
    );

    modport master (
        output ADR_I, DAT_I, SEL_I, TGA_I, TGC_I, WE_I, reply_i,
        output is_valid_i, last_i, abort_i, ready_i,
        input  stall_o, overflow_o, is_valid_o, adr_o, tga_o, tgc_o,
        input  we_o, reply_o, data_o, sel_o, len_o, vnet_id_o
    );
endinterface

// File: rtl/multi_message_buffer.sv
// Assembles bus words into whole messages held in a small circular queue of
// slots; the oldest complete message is presented combinationally at the head.
module multi_message_buffer #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int SEL_W          = 4,
    parameter int TGA_W          = 2,
    parameter int TGC_W          = 2,
    parameter int MAX_BURST      = 8,
    parameter int N_SLOTS        = 2,
    parameter int N_BITS_VNET_ID = 2,
    parameter int VNET_LSB       = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multi_message_buffer_if.slave   bus
);
    localparam int IDX_W = $clog2(MAX_BURST);
    localparam int LEN_W = IDX_W + 1;
    localparam int PTR_W = $clog2(N_SLOTS);
    localparam int FC_W  = $clog2(N_SLOTS + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]       state_reg;
    logic [IDX_W-1:0] chunk_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [FC_W-1:0]  full_cnt_reg;
    logic             overflow_reg;

    logic [MAX_BURST*DATA_W-1:0] data_mem  [N_SLOTS];
    logic [MAX_BURST*SEL_W-1:0]  sel_mem   [N_SLOTS];
    logic [ADDR_W-1:0]           adr_mem   [N_SLOTS];
    logic [TGA_W-1:0]            tga_mem   [N_SLOTS];
    logic [TGC_W-1:0]            tgc_mem   [N_SLOTS];
    logic                        we_mem    [N_SLOTS];
    logic                        reply_mem [N_SLOTS];
    logic [LEN_W-1:0]            len_mem   [N_SLOTS];

    logic stall;
    logic head_valid;
    logic accept;
    logic drop;
    logic complete;
    logic pop;

    assign stall      = (full_cnt_reg == FC_W'(N_SLOTS));
    assign head_valid = (full_cnt_reg != '0);
    // abort_i outranks is_valid_i: an aborting word is neither stored nor counted as dropped
    assign accept     = bus.is_valid_i && !stall && !bus.abort_i;
    assign drop       = bus.is_valid_i && stall && !bus.abort_i;
    assign complete   = accept && (bus.last_i || (chunk_reg == IDX_W'(MAX_BURST - 1)));
    assign pop        = head_valid && bus.ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            chunk_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            full_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= drop;
            if (bus.abort_i) begin
                state_reg <= IDLE;
                chunk_reg <= '0;
            end else if (accept) begin
                if (complete) begin
                    state_reg  <= IDLE;
                    chunk_reg  <= '0;
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                end else begin
                    state_reg <= FILL;
                    chunk_reg <= chunk_reg + IDX_W'(1);
                end
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({complete, pop})
                2'b10:   full_cnt_reg <= full_cnt_reg + FC_W'(1);
                2'b01:   full_cnt_reg <= full_cnt_reg - FC_W'(1);
                default: full_cnt_reg <= full_cnt_reg;
            endcase
        end
    end

    // The first word of a message zeroes the rest of its select row, so
    // selects past the final length read back as 0 without a clear pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < N_SLOTS; s++) begin
                sel_mem[s] <= '0;
            end
        end else if (accept) begin
            if (state_reg == IDLE) begin
                sel_mem[wr_ptr_reg] <= (MAX_BURST*SEL_W)'(bus.SEL_I);
            end else begin
                sel_mem[wr_ptr_reg][int'(chunk_reg)*SEL_W +: SEL_W] <= bus.SEL_I;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_mem[wr_ptr_reg][int'(chunk_reg)*DATA_W +: DATA_W] <= bus.DAT_I;
            if (state_reg == IDLE) begin
                adr_mem[wr_ptr_reg]   <= bus.ADR_I;
                tga_mem[wr_ptr_reg]   <= bus.TGA_I;
                tgc_mem[wr_ptr_reg]   <= bus.TGC_I;
                we_mem[wr_ptr_reg]    <= bus.WE_I;
                reply_mem[wr_ptr_reg] <= bus.reply_i;
            end
            if (complete) begin
                len_mem[wr_ptr_reg] <= {1'b0, chunk_reg} + LEN_W'(1);
            end
        end
    end

    assign bus.stall_o    = stall;
    assign bus.overflow_o = overflow_reg;
    assign bus.is_valid_o = head_valid;
    assign bus.adr_o      = adr_mem[rd_ptr_reg];
    assign bus.tga_o      = tga_mem[rd_ptr_reg];
    assign bus.tgc_o      = tgc_mem[rd_ptr_reg];
    assign bus.we_o       = we_mem[rd_ptr_reg];
    assign bus.reply_o    = reply_mem[rd_ptr_reg];
    assign bus.data_o     = data_mem[rd_ptr_reg];
    assign bus.sel_o      = sel_mem[rd_ptr_reg];
    // Length and vnet are gated so an empty queue shows zeros rather than a stale slot
    assign bus.len_o      = head_valid ? len_mem[rd_ptr_reg] : '0;
    assign bus.vnet_id_o  = head_valid ? data_mem[rd_ptr_reg][VNET_LSB +: N_BITS_VNET_ID] : '0;
endmodule

// File: tb/tb_multi_message_buffer.sv
// Directed bench for multi_message_buffer with default parameters
// (MAX_BURST=8, N_SLOTS=2); expected values are worked out by hand per step.
module tb_multi_message_buffer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    multi_message_buffer_if bus ();

    multi_message_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic last);
        bus.ADR_I      = adr;
        bus.DAT_I      = dat;
        bus.SEL_I      = sel;
        bus.last_i     = last;
        bus.is_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.is_valid_i = 1'b0;
        bus.last_i     = 1'b0;
        $display("put adr=%0h dat=%0h sel=%0h last=%0b -> valid=%0b stall=%0b len=%0d",
                 adr, dat, sel, last, bus.is_valid_o, bus.stall_o, bus.len_o);
    endtask

    task automatic pop_one();
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
        $display("pop -> valid=%0b stall=%0b adr=%0h len=%0d",
                 bus.is_valid_o, bus.stall_o, bus.adr_o, bus.len_o);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.ADR_I      = '0;
        bus.DAT_I      = '0;
        bus.SEL_I      = '0;
        bus.TGA_I      = '0;
        bus.TGC_I      = '0;
        bus.WE_I       = 1'b0;
        bus.reply_i    = 1'b0;
        bus.is_valid_i = 1'b0;
        bus.last_i     = 1'b0;
        bus.abort_i    = 1'b0;
        bus.ready_i    = 1'b0;

        #2;
        check("rst_valid", bus.is_valid_o, 1'b0);
        check("rst_stall", bus.stall_o, 1'b0);
        check("rst_len", bus.len_o, 4'd0);
        check("rst_vnet", bus.vnet_id_o, 2'd0);
        check("rst_ovf", bus.overflow_o, 1'b0);
        check("rst_sel", bus.sel_o, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3-word message; sideband taken from the first word only
        bus.TGA_I = 2'd2; bus.TGC_I = 2'd1; bus.WE_I = 1'b1; bus.reply_i = 1'b1;
        put(32'h1000, 32'hA000_0001, 4'hF, 1'b0);
        bus.TGA_I = 2'd0; bus.TGC_I = 2'd0; bus.WE_I = 1'b0; bus.reply_i = 1'b0;
        put(32'h2000, 32'hA000_0002, 4'h3, 1'b0);
        check("a_partial_valid", bus.is_valid_o, 1'b0);
        put(32'h3000, 32'hA000_0003, 4'h1, 1'b1);
        check("a_valid", bus.is_valid_o, 1'b1);
        check("a_len", bus.len_o, 4'd3);
        check("a_sel", bus.sel_o, 32'h0000_013F);
        check("a_adr", bus.adr_o, 32'h1000);
        check("a_data", bus.data_o[95:0], 96'hA0000003_A0000002_A0000001);
        check("a_vnet", bus.vnet_id_o, 2'd1);
        check("a_tags", {bus.tga_o, bus.tgc_o, bus.we_o, bus.reply_o}, 6'b10_01_1_1);
        check("a_stall", bus.stall_o, 1'b0);
        pop_one();
        check("a_pop_valid", bus.is_valid_o, 1'b0);
        check("a_pop_len", bus.len_o, 4'd0);

        // Fill both slots, then one word too many
        put(32'h10, 32'h11, 4'h1, 1'b1);
        check("b_valid", bus.is_valid_o, 1'b1);
        check("b_stall0", bus.stall_o, 1'b0);
        put(32'h20, 32'h22, 4'h2, 1'b1);
        check("b_stall1", bus.stall_o, 1'b1);
        check("b_ovf0", bus.overflow_o, 1'b0);
        put(32'h30, 32'h33, 4'h4, 1'b1);
        check("b_ovf_pulse", bus.overflow_o, 1'b1);
        check("b_head_data", bus.data_o[31:0], 32'h11);
        check("b_head_sel", bus.sel_o, 32'h1);
        check("b_head_len", bus.len_o, 4'd1);
        check("b_head_stable_adr", bus.adr_o, 32'h10);
        @(posedge clk);
        #1;
        check("b_ovf_clear", bus.overflow_o, 1'b0);
        check("b_still_stall", bus.stall_o, 1'b1);
        pop_one();
        check("b_second_adr", bus.adr_o, 32'h20);
        check("b_second_data", bus.data_o[31:0], 32'h22);
        check("b_unstall", bus.stall_o, 1'b0);
        pop_one();
        check("b_empty", bus.is_valid_o, 1'b0);

        // 8 words with no last_i auto-complete; 9th starts a new slot
        for (int k = 0; k < 8; k++) begin
            put(32'h500 + 32'(k), 32'hB0 + 32'(k), 4'(k + 1), 1'b0);
            if (k == 6) check("c_7words_valid", bus.is_valid_o, 1'b0);
        end
        check("c_valid", bus.is_valid_o, 1'b1);
        check("c_len", bus.len_o, 4'd8);
        check("c_sel", bus.sel_o, 32'h8765_4321);
        check("c_word7", bus.data_o[255:224], 32'hB7);
        check("c_adr", bus.adr_o, 32'h500);
        put(32'h600, 32'hC0, 4'hF, 1'b1);
        check("c_ninth_stall", bus.stall_o, 1'b1);
        check("c_head_len_kept", bus.len_o, 4'd8);
        pop_one();
        check("c_second_adr", bus.adr_o, 32'h600);
        check("c_second_len", bus.len_o, 4'd1);
        check("c_second_sel", bus.sel_o, 32'h0000_000F);
        pop_one();
        check("c_empty", bus.is_valid_o, 1'b0);

        // Abort a 2-word partial message; an aborting word is not stored
        put(32'h700, 32'h71, 4'hF, 1'b0);
        put(32'h700, 32'h72, 4'hF, 1'b0);
        bus.abort_i = 1'b1;
        put(32'h777, 32'hDEAD, 4'hF, 1'b1);
        bus.abort_i = 1'b0;
        check("d_abort_valid", bus.is_valid_o, 1'b0);
        check("d_abort_stall", bus.stall_o, 1'b0);
        put(32'h800, 32'hD1, 4'h5, 1'b1);
        check("d_valid", bus.is_valid_o, 1'b1);
        check("d_len", bus.len_o, 4'd1);
        check("d_adr", bus.adr_o, 32'h800);
        check("d_sel", bus.sel_o, 32'h0000_0005);
        check("d_data", bus.data_o[31:0], 32'hD1);
        check("d_stall", bus.stall_o, 1'b0);
        pop_one();
        check("d_empty", bus.is_valid_o, 1'b0);

        // Completion and pop on the same edge keep the count at 1
        put(32'h900, 32'hE1, 4'h1, 1'b1);
        put(32'hA00, 32'hE2, 4'h3, 1'b0);
        bus.ready_i = 1'b1;
        put(32'hA00, 32'hE3, 4'h7, 1'b1);
        bus.ready_i = 1'b0;
        check("e_valid", bus.is_valid_o, 1'b1);
        check("e_stall", bus.stall_o, 1'b0);
        check("e_adr", bus.adr_o, 32'hA00);
        check("e_len", bus.len_o, 4'd2);
        check("e_word1", bus.data_o[63:32], 32'hE3);
        check("e_sel", bus.sel_o, 32'h0000_0073);
        put(32'hB00, 32'hE4, 4'h1, 1'b1);
        check("e_now_full", bus.stall_o, 1'b1);
        pop_one();
        check("e_head_b00", bus.adr_o, 32'hB00);
        check("e_one_left", bus.stall_o, 1'b0);

        // Asynchronous reset mid-message with one full slot
        put(32'hC00, 32'hC1, 4'hF, 1'b0);
        rst_n = 1'b0;
        #2;
        check("f_rst_valid", bus.is_valid_o, 1'b0);
        check("f_rst_stall", bus.stall_o, 1'b0);
        check("f_rst_len", bus.len_o, 4'd0);
        check("f_rst_sel", bus.sel_o, 32'h0);
        check("f_rst_vnet", bus.vnet_id_o, 2'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("f_post_rst_valid", bus.is_valid_o, 1'b0);
        put(32'hD00, 32'hF2, 4'h3, 1'b1);
        check("f_new_valid", bus.is_valid_o, 1'b1);
        check("f_new_len", bus.len_o, 4'd1);
        check("f_new_adr", bus.adr_o, 32'hD00);
        check("f_new_sel", bus.sel_o, 32'h0000_0003);
        check("f_new_data", bus.data_o[31:0], 32'hF2);
        check("f_new_vnet", bus.vnet_id_o, 2'd2);
        check("f_new_stall", bus.stall_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_message_buffer.md
MULTI_MESSAGE_BUFFER -- requirements
Module: multi_message_buffer

Interface
REQ-001 SHALL have parameters, one per line:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width
- SEL_W, 4, byte-select width
- TGA_W, 2, address-tag width
- TGC_W, 2, cycle-tag width
- MAX_BURST, 8, max data words per message (>=2)
- N_SLOTS, 2, message slots (power of 2, >=2)
- N_BITS_VNET_ID, 2, vnet field width
- VNET_LSB, 0, LSB of vnet field in data word 0
REQ-002 SHALL have ports, one per line (name direction width meaning):
- clk in 1 single clock, rising edge
- rst_n in 1 asynchronous active-low reset
- ADR_I in ADDR_W bus address
- DAT_I in DATA_W bus data word
- SEL_I in SEL_W byte select
- TGA_I in TGA_W address tag
- TGC_I in TGC_W cycle tag
- WE_I in 1 write/read cycle flag
- reply_i in 1 message is a reply for the master interface
- is_valid_i in 1 input word valid
- last_i in 1 input word is last of message
- abort_i in 1 discard partially filled message
- stall_o out 1 no free slot; input word not accepted
- overflow_o out 1 one-cycle pulse: word dropped
- is_valid_o out 1 head slot holds complete message
- ready_i in 1 consumer accepts head message
- adr_o out ADDR_W head message address
- tga_o out TGA_W head address tag
- tgc_o out TGC_W head cycle tag
- we_o out 1 head WE
- reply_o out 1 head reply flag
- data_o out MAX_BURST*DATA_W head data, word k at bits [DATA_W*(k+1)-1:DATA_W*k]
- sel_o out MAX_BURST*SEL_W head selects, same packing
- len_o out clog2(MAX_BURST)+1 head word count, 1..MAX_BURST
- vnet_id_o out N_BITS_VNET_ID head vnet id

Function
REQ-003 SHALL hold N_SLOTS slots in a circular queue: wr_ptr (filling slot), rd_ptr (head), full_cnt 0..N_SLOTS; pointers wrap N_SLOTS-1 -> 0.
REQ-004 Fill FSM SHALL have states IDLE (no partial message) and FILL (wr slot partially written, chunk count 1..MAX_BURST-1).
REQ-005 stall_o SHALL equal (full_cnt==N_SLOTS), combinational.
REQ-006 Word accepted when is_valid_i && !stall_o; stored at index chunk count of wr slot; DAT_I/SEL_I captured per word; ADR_I, TGA_I, TGC_I, WE_I, reply_i captured only on first word (IDLE).
REQ-007 Message completes on accepted word with last_i=1 or with chunk count reaching MAX_BURST; completion SHALL set slot len, increment wr_ptr, increment full_cnt, return FSM to IDLE; single-word message with last_i goes IDLE->IDLE.
REQ-008 Accepted word without completion: IDLE->FILL, or FILL stays with count+1.
REQ-009 On completion, sel entries beyond len SHALL read 0; data beyond len is don't-care.
REQ-010 is_valid_i while stall_o=1 SHALL drop the word, leave state unchanged, pulse overflow_o next cycle.
REQ-011 abort_i SHALL have priority over is_valid_i: discard partial message, chunk count 0, FSM IDLE, wr_ptr/full_cnt unchanged; completed slots unaffected.
REQ-012 is_valid_o SHALL equal (full_cnt!=0); head outputs SHALL reflect slot rd_ptr with zero-cycle latency.
REQ-013 Pop on is_valid_o && ready_i: rd_ptr+1, full_cnt-1 at clock edge; ready_i with is_valid_o=0 SHALL be ignored.
REQ-014 Simultaneous completion and pop SHALL leave full_cnt unchanged, both pointers advance.
REQ-015 vnet_id_o SHALL be data word 0 bits [VNET_LSB+N_BITS_VNET_ID-1:VNET_LSB] of head when is_valid_o, else 0.
REQ-016 Head outputs SHALL stay stable while is_valid_o && !ready_i.
REQ-017 Latency: last word accepted at edge n -> is_valid_o high after edge n (queue previously empty).

Reset
REQ-018 rst_n=0 SHALL asynchronously clear wr_ptr, rd_ptr, full_cnt, chunk count, all sel storage, overflow_o; FSM IDLE; is_valid_o=0, stall_o=0, vnet_id_o=0, len_o=0; data/address storage need not reset.
REQ-019 Reset mid-message or with full queue SHALL discard all content; first accepted word after release starts a new message.

Verification
REQ-020 3 words, last_i on third, ready_i=0 -> is_valid_o=1, len_o=3, sel_o upper 5 fields 0, adr_o = first ADR_I.
REQ-021 N_SLOTS=2: two 1-word messages, ready_i=0, third word -> stall_o=1, overflow_o pulses once, head data unchanged.
REQ-022 8 consecutive words, no last_i, MAX_BURST=8 -> auto-complete, len_o=8; 9th word starts new slot.
REQ-023 2 words then abort_i, then 1-word message with last_i -> only message len_o=1 visible.
REQ-024 Full queue, ready_i=1 same cycle last word arrives into freed slot scenario (full_cnt=1, pop and complete same edge) -> full_cnt stays 1, new message becomes head.
REQ-025 rst_n low mid-FILL with 1 full slot -> is_valid_o=0 immediately, stall_o=0, full_cnt=0.
